// File: rtl/video_timing_tx.sv
// video_timing_tx
//   Output end of the video path. Generates raster timing (hsync, vsync, data
//   enable) on the pixel clock and drains an RGB565 valid/ready pixel stream
//   into the active area. The stream is frame-locked on its start-of-frame tag.
//   The block also reports two sticky errors: underflow, and a start-of-frame
//   tag that does not line up with the raster origin.
//
//   Ports
//     clk, rst          pixel clock, asynchronous active-high reset
//     en                1: timing runs, 0: counters/state held idle, outputs inactive
//     s_data/s_valid/s_sof/s_ready
//                       RGB565 pixel stream. s_ready is combinational.
//     vo_hs/vo_vs       sync outputs, active level set by HS_POL/VS_POL
//     vo_de/vo_data     active video enable and pixel
//     underflow         sticky: an active pixel was needed but none was valid
//     sof_err           sticky: s_sof was seen away from the raster origin
//     clr_status        synchronous clear of both sticky flags (beats a same-cycle set)
//
//   Optional build macro VTX_TEST_PATTERN_EN adds input pattern_en. When it is
//   high, the active area shows eight vertical colour bars. The stream is left
//   untouched and the lock state is held in SYNC.
module video_timing_tx #(
  parameter int          H_SYNC  = 40,
  parameter int          H_BACK  = 220,
  parameter int          H_DISP  = 1280,
  parameter int          H_FRONT = 110,
  parameter int          V_SYNC  = 5,
  parameter int          V_BACK  = 20,
  parameter int          V_DISP  = 720,
  parameter int          V_FRONT = 5,
  parameter logic        HS_POL  = 1'b1,
  parameter logic        VS_POL  = 1'b1,
  parameter logic [15:0] FILL    = 16'h0000,
  parameter int          CNT_W   = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
`ifdef VTX_TEST_PATTERN_EN
  input  logic        pattern_en,
`endif
  input  logic [15:0] s_data,
  input  logic        s_valid,
  input  logic        s_sof,
  output logic        s_ready,
  output logic        vo_hs,
  output logic        vo_vs,
  output logic        vo_de,
  output logic [15:0] vo_data,
  output logic        underflow,
  output logic        sof_err,
  input  logic        clr_status
);

  localparam int H_TOT = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_TOT = V_SYNC + V_BACK + V_DISP + V_FRONT;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOT - 1);
  localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] HA_BEG  = CNT_W'(H_SYNC + H_BACK);
  localparam logic [CNT_W-1:0] HA_END  = CNT_W'(H_SYNC + H_BACK + H_DISP);
  localparam logic [CNT_W-1:0] VA_BEG  = CNT_W'(V_SYNC + V_BACK);
  localparam logic [CNT_W-1:0] VA_END  = CNT_W'(V_SYNC + V_BACK + V_DISP);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
  logic             de_q, de_d;
  logic [15:0]      data_q, data_d;
  logic             uf_q, uf_d;
  logic             se_q, se_d;

  logic             hs_int, vs_int, de_int, origin;
  logic             pop, uf_set, se_set;

`ifdef VTX_TEST_PATTERN_EN
  localparam logic [CNT_W-1:0] BAR_W = CNT_W'(H_DISP / 8);

  logic [CNT_W-1:0] bar_sel;
  logic [2:0]       bar_idx;
  logic [15:0]      bar_pix;

  // Bars run left to right: white, yellow, cyan, green, magenta, red, blue, black.
  function automatic logic [15:0] bar_colour(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = 16'hFFFF;
      3'd1:    c = 16'hFFE0;
      3'd2:    c = 16'h07FF;
      3'd3:    c = 16'h07E0;
      3'd4:    c = 16'hF81F;
      3'd5:    c = 16'hF800;
      3'd6:    c = 16'h001F;
      default: c = 16'h0000;
    endcase
    return c;
  endfunction

  // Colour bar selection from the horizontal position inside the active area.
  always_comb begin
    bar_sel = (h_cnt_q - HA_BEG) / BAR_W;
    bar_idx = (bar_sel > CNT_W'(7)) ? 3'd7 : bar_sel[2:0];
    bar_pix = bar_colour(bar_idx);
  end
`endif

  // Raster decode of the current counter position.
  always_comb begin
    hs_int = (h_cnt_q < HS_END);
    vs_int = (v_cnt_q < VS_END);
    de_int = (h_cnt_q >= HA_BEG) && (h_cnt_q < HA_END) &&
             (v_cnt_q >= VA_BEG) && (v_cnt_q < VA_END);
    origin = (h_cnt_q == HA_BEG) && (v_cnt_q == VA_BEG);
  end

  // Horizontal / vertical counters. Disabling parks them at the frame start.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (!en) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
    end else if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      if (v_cnt_q == V_LAST) begin
        v_cnt_d = '0;
      end else begin
        v_cnt_d = v_cnt_q + CNT_ONE;
      end
    end else begin
      h_cnt_d = h_cnt_q + CNT_ONE;
    end
  end

  // Lock state machine: decides pop, output pixel and error events.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    uf_set  = 1'b0;
    se_set  = 1'b0;
    data_d  = de_int ? FILL : 16'h0000;
    if (!en) begin
      state_d = ST_IDLE;
      data_d  = 16'h0000;
    end else
`ifdef VTX_TEST_PATTERN_EN
    if (pattern_en) begin
      state_d = ST_SYNC;
      data_d  = de_int ? bar_pix : 16'h0000;
    end else
`endif
    begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_SYNC;
        end
        ST_SYNC: begin
          // Untagged pixels are stale leftovers of an earlier frame: drop them.
          // A tagged pixel waits at the head until the raster reaches the origin.
          if (s_valid && !s_sof) begin
            pop = 1'b1;
          end else if (s_valid && origin) begin
            pop     = 1'b1;
            data_d  = s_data;
            state_d = ST_RUN;
          end else begin
            state_d = ST_SYNC;
          end
        end
        ST_RUN: begin
          if (de_int) begin
            if (!s_valid) begin
              uf_set = 1'b1;
            end else if (s_sof == origin) begin
              pop    = 1'b1;
              data_d = s_data;
            end else begin
              // Tag disagrees with the raster. Keep the pixel at the head so
              // that a misplaced sof can start the next frame.
              se_set  = 1'b1;
              state_d = ST_SYNC;
            end
          end else begin
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Next values of the registered video outputs and sticky flags.
  always_comb begin
    hs_d = (en && hs_int) ? HS_POL : ~HS_POL;
    vs_d = (en && vs_int) ? VS_POL : ~VS_POL;
    de_d = en && de_int;
    if (clr_status || !en) begin
      uf_d = 1'b0;
      se_d = 1'b0;
    end else begin
      uf_d = uf_q | uf_set;
      se_d = se_q | se_set;
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      hs_q    <= ~HS_POL;
      vs_q    <= ~VS_POL;
      de_q    <= 1'b0;
      data_q  <= 16'h0000;
      uf_q    <= 1'b0;
      se_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      de_q    <= de_d;
      data_q  <= data_d;
      uf_q    <= uf_d;
      se_q    <= se_d;
    end
  end

  assign s_ready   = pop;
  assign vo_hs     = hs_q;
  assign vo_vs     = vs_q;
  assign vo_de     = de_q;
  assign vo_data   = data_q;
  assign underflow = uf_q;
  assign sof_err   = se_q;

endmodule

// File: tb/tb_video_timing_tx.sv
// tb_video_timing_tx
//   Directed bench for video_timing_tx using a small raster. The raster is
//   14 clocks per line and 7 lines per frame, so one frame is 98 clocks. The
//   active area is h 4..11 and v 2..5, and the origin is at raster position 32.
//   Expected outputs are worked out from the raster position. For each
//   scenario, the bench also uses a hand-derived rule for which pixel belongs
//   at each active slot.
module tb_video_timing_tx;

  localparam int          HT     = 14;
  localparam int          FT     = 98;
  localparam logic [15:0] FILL_C = 16'hF0F0;

  logic        clk = 1'b0;
  logic        rst, en, s_valid, s_sof, s_ready, clr_status;
  logic [15:0] s_data;
  logic        vo_hs, vo_vs, vo_de, underflow, sof_err;
  logic [15:0] vo_data;

  int n_chk, n_pass;
  int pos;
  int gap_a, gap_b, clr_a, clr_b;
  int de_cnt, hs_cnt, vs_cnt;
  logic [16:0] src_q[$];

  always #5 clk = ~clk;

  video_timing_tx #(
    .H_SYNC(2), .H_BACK(2), .H_DISP(8), .H_FRONT(2),
    .V_SYNC(1), .V_BACK(1), .V_DISP(4), .V_FRONT(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .FILL(FILL_C), .CNT_W(12)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
`ifdef VTX_TEST_PATTERN_EN
    .pattern_en(1'b0),
`endif
    .s_data(s_data), .s_valid(s_valid), .s_sof(s_sof), .s_ready(s_ready),
    .vo_hs(vo_hs), .vo_vs(vo_vs), .vo_de(vo_de), .vo_data(vo_data),
    .underflow(underflow), .sof_err(sof_err), .clr_status(clr_status)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] got_vec();
    return {11'd0, vo_hs, vo_vs, vo_de, underflow, sof_err, vo_data};
  endfunction

  // Expected output word for raster position p (counted from enable) in a scenario.
  function automatic logic [31:0] exp_vec(input int mode, input int p);
    int fp, h, v, fr, a;
    logic hs, vs, de, uf, se;
    logic [15:0] d;
    fp = p % FT; h = fp % HT; v = fp / HT; fr = p / FT;
    hs = (h < 2);
    vs = (v < 1);
    de = (h >= 4) && (h < 12) && (v >= 2) && (v < 6);
    a  = (v - 2) * 8 + (h - 4);
    case (mode)
      1:       d = 16'(a);
      2:       d = (a < 10) ? 16'(a) : ((a < 12) ? FILL_C : 16'(a - 2));
      3:       d = (fr == 0) ? ((a < 5) ? 16'(a) : FILL_C) : 16'(a + 5);
      default: d = FILL_C;
    endcase
    uf = (mode == 2) && (p >= 49) && (p < 90);
    se = (mode == 3) && (p >= 37) && (p < 188);
    return {11'd0, hs, vs, de, uf, se, de ? d : 16'h0000};
  endfunction

  task automatic drive();
    s_valid    = (src_q.size() > 0) && (pos != gap_a) && (pos != gap_b);
    if (src_q.size() > 0) {s_sof, s_data} = src_q[0];
    else {s_sof, s_data} = 17'd0;
    clr_status = (pos == clr_a) || (pos == clr_b);
  endtask

  task automatic step();
    logic rdy;
    @(negedge clk);
    rdy = s_ready;
    @(posedge clk);
    #1;
    if (rdy && src_q.size() > 0) void'(src_q.pop_front());
    pos++;
    drive();
  endtask

  task automatic load_frame(input int base, input int extra_sof);
    for (int i = 0; i < 32; i++)
      src_q.push_back({(i == 0) || (i == extra_sof), 16'(base + i)});
  endtask

  task automatic start();
    en  = 1'b1;
    pos = 0;
    drive();
  endtask

  task automatic restart();
    @(posedge clk); #1;
    en = 1'b0;
    src_q.delete();
    gap_a = -1; gap_b = -1; clr_a = -1; clr_b = -1;
    drive();
    @(posedge clk); #1;
  endtask

  task automatic run(input string tag, input int mode, input int nsteps);
    de_cnt = 0; hs_cnt = 0; vs_cnt = 0;
    for (int i = 0; i < nsteps; i++) begin
      step();
      de_cnt += int'(vo_de);
      hs_cnt += int'(vo_hs);
      vs_cnt += int'(vo_vs);
      check_eq($sformatf("%s@%0d", tag, pos - 1), got_vec(), exp_vec(mode, pos - 1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    n_chk = 0; n_pass = 0; pos = 0;
    gap_a = -1; gap_b = -1; clr_a = -1; clr_b = -1;
    rst = 1'b1; en = 1'b0; s_valid = 1'b0; s_sof = 1'b0; s_data = 16'h0000; clr_status = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check_eq("reset", got_vec(), 32'h0000_0000);

    // Free run with no source: timing only, FILL on active pixels.
    start();
    run("free", 0, 98);
    check_eq("de_count", 32'(de_cnt), 32'd32);
    check_eq("hs_count", 32'(hs_cnt), 32'd14);
    check_eq("vs_count", 32'(vs_cnt), 32'd14);

    // Continuous frames lock at the origin and play out in raster order.
    restart();
    load_frame(0, -1); load_frame(0, -1);
    start();
    run("lock", 1, 196);

    // Three stale pixels before the sof are discarded.
    restart();
    src_q.push_back({1'b0, 16'd100}); src_q.push_back({1'b0, 16'd101}); src_q.push_back({1'b0, 16'd102});
    load_frame(0, -1);
    start();
    run("midstart", 1, 98);
    check_eq("midstart_drained", 32'(src_q.size()), 32'd0);

    // Two-clock valid gap on the second active line; clear beats set on the first.
    restart();
    load_frame(0, -1);
    gap_a = 48; gap_b = 49; clr_a = 48; clr_b = 90;
    start();
    run("gap", 2, 98);

    // Extra sof at pixel 5, relock on that pixel in the next frame.
    restart();
    load_frame(0, 5);
    for (int i = 32; i < 37; i++) src_q.push_back({1'b0, 16'(i)});
    clr_a = 188;
    start();
    run("xsof", 3, 196);

    // Asynchronous reset mid-line clears outputs without waiting for a clock.
    restart();
    load_frame(0, 5);
    start();
    run("prerst", 3, 45);
    rst = 1'b1;
    #1;
    check_eq("rst_async", got_vec(), 32'h0000_0000);
    en = 1'b0;
    src_q.delete();
    drive();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // en low mid-frame: no consumption, reset outputs after one clock, relock after stale data.
    @(posedge clk); #1;
    load_frame(0, -1); load_frame(0, -1);
    start();
    run("pre_en0", 1, 38);
    en = 1'b0;
    #1;
    check_eq("en0_ready", {31'd0, s_ready}, 32'd0);
    step();
    check_eq("en0_out", got_vec(), 32'h0000_0000);
    @(posedge clk); #1;
    start();
    run("relock", 1, 98);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
